// File: rtl/uart_pkg.sv
// Shared UART definitions: tx FSM state type, oversample ratio and frame defaults.
// UART_TX_PARITY_EN adds the PARITY state to the enumeration.
package uart_pkg;

   localparam int OVERSAMPLE  = 16;
   localparam int DBIT_DEF    = 6;
   localparam int SB_TICK_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_flag.sv
// UART transmitter fed by a one-word flag buffer; 16x oversampled via s_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_flag
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_flag,
   input  logic [DBIT-1:0] tx_din,
   output logic            tx_clr_flag,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            tx
);

   localparam int NBW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [3:0]     TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]     STOP_LAST = 4'(SB_TICK - 1);
   localparam logic [NBW-1:0] BIT_LAST  = NBW'(DBIT - 1);

   tx_state_t       state;
   logic [3:0]      s_reg;
   logic [NBW-1:0]  n_reg;
   logic [DBIT-1:0] b_reg;
   logic [DBIT-1:0] b_next;
`ifdef UART_TX_PARITY_EN
   logic            par_bit;
`endif

   assign b_next = b_reg >> 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         s_reg        <= '0;
         n_reg        <= '0;
         b_reg        <= '0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_clr_flag  <= 1'b0;
         tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit      <= 1'b0;
`endif
      end else begin
         tx_clr_flag  <= 1'b0;
         tx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               // The done-tick cycle is never an accepting cycle, so frames are
               // always separated by a full idle cycle.
               if (tx_flag && !tx_done_tick) begin
                  b_reg       <= tx_din;
                  s_reg       <= '0;
                  n_reg       <= '0;
                  state       <= START;
                  tx          <= 1'b0;
                  tx_busy     <= 1'b1;
                  tx_clr_flag <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  par_bit     <= ^tx_din;
`endif
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_reg == TICK_LAST) begin
                     s_reg <= '0;
                     state <= DATA;
                     tx    <= b_reg[0];
                  end else begin
                     s_reg <= s_reg + 4'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_reg == TICK_LAST) begin
                     s_reg <= '0;
                     b_reg <= b_next;
                     if (n_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par_bit;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                     end else begin
                        n_reg <= n_reg + NBW'(1);
                        tx    <= b_next[0];
                     end
                  end else begin
                     s_reg <= s_reg + 4'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s_reg == TICK_LAST) begin
                     s_reg <= '0;
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     s_reg <= s_reg + 4'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s_reg == STOP_LAST) begin
                     s_reg        <= '0;
                     state        <= IDLE;
                     tx_busy      <= 1'b0;
                     tx_done_tick <= 1'b1;
                  end else begin
                     s_reg <= s_reg + 4'd1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
